pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Control-side counterpart of the 5-stage pipeline registers: generates every stall, flush and bubble signal that the IF/ID, ID/EX, EX/MEM and MEM/WB registers consume.
- Detects four conditions: load-use hazards, EX-stage redirects (branches and jumps), data-memory wait states and instruction-memory wait states.
- Contains a memory-wait FSM with a timeout watchdog and a post-redirect shadow flush register.

Parameters:
TIMEOUT, 64, maximum number of consecutive frozen data-memory wait cycles before forced release.
CNT_W, 8, width of wait_count; must satisfy 2^CNT_W > TIMEOUT.
REDIRECT_SHADOW, 1, 1 = also flush IF/ID in the cycle after a redirect (for a 1-cycle-latency imem); 0 = no shadow flush.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
ID_Rs1  in  5  decode-stage source register 1
ID_Rs2  in  5  decode-stage source register 2
ID_UsesRs1  in  1  decode instruction reads rs1
ID_UsesRs2  in  1  decode instruction reads rs2
EX_Rd  in  5  execute-stage destination register
EX_MemRead  in  1  execute-stage instruction is a load
EX_Redirect  in  1  EX resolved a taken branch or jump; PC is redirected this cycle
MEM_MemRead  in  1  MEM-stage load
MEM_MemWrite  in  1  MEM-stage store
dmem_ready  in  1  data memory completes the access this cycle
imem_ready  in  1  instruction memory has valid data this cycle
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  bubble IF/ID
id_ex_stall  out  1  hold ID/EX
id_ex_flush  out  1  bubble ID/EX
ex_mem_stall  out  1  hold EX/MEM
mem_wb_flush  out  1  bubble MEM/WB
mem_fault  out  1  sticky: a dmem timeout has occurred
wait_count  out  CNT_W  number of frozen cycles in the current wait

Behaviour:
- Reset is asynchronous: state=RUN, wait_count=0, mem_fault=0, shadow=0.
- While reset is held, all stall and flush outputs are 0.
- Stall and flush outputs are combinational from state, registers and inputs. There is no added latency.
- Derived terms:
  - mem_access = MEM_MemRead | MEM_MemWrite.
  - load_use = EX_MemRead & EX_Rd!=0 & ((ID_UsesRs1 & ID_Rs1==EX_Rd) | (ID_UsesRs2 & ID_Rs2==EX_Rd)).
  - redir = EX_Redirect | shadow.
- freeze = mem_access & !dmem_ready & !(state==WAIT & wait_count==TIMEOUT).
- Output priority, highest first; exactly one row applies per cycle.
  1. freeze: pc_stall, if_id_stall, id_ex_stall and ex_mem_stall = 1; mem_wb_flush = 1. All other flushes are 0.
  2. redir: if_id_flush = 1 and id_ex_flush = 1. All stalls are 0 so the redirected PC loads.
  3. load_use: pc_stall = 1, if_id_stall = 1, id_ex_flush = 1 (one bubble).
  4. !imem_ready: pc_stall = 1, if_id_flush = 1.
  5. Otherwise: all outputs are 0.
- if_id_stall and if_id_flush are never both 1.
- id_ex_stall and id_ex_flush are never both 1.
- FSM RUN:
  - freeze → WAIT, wait_count <= 1.
  - Otherwise stay in RUN, wait_count <= 0.
- FSM WAIT:
  - dmem_ready=1 → RUN, wait_count <= 0. No freeze in that cycle.
  - dmem_ready=0 and wait_count<TIMEOUT → stay in WAIT, wait_count <= wait_count+1. Freeze held.
  - dmem_ready=0 and wait_count==TIMEOUT → freeze deasserts this cycle (forced release, instruction retires with undefined data). Next edge: mem_fault <= 1, state → RUN, wait_count <= 0.
  - mem_access dropping to 0 in WAIT → RUN, wait_count <= 0. This is a protocol error, handled without setting mem_fault.
- mem_fault clears only on reset.
- Shadow register:
  - REDIRECT_SHADOW=1: shadow <= EX_Redirect & !freeze.
  - REDIRECT_SHADOW=0: shadow is held at 0.
  - A redirect that occurs during a freeze is re-evaluated once the freeze releases, because the EX stage is held with its inputs unchanged.
- Simultaneous redirect and load-use: redirect wins, and the load-use stall is dropped because the dependent instruction is flushed.
- Reset asserted mid-WAIT returns the block to RUN immediately. wait_count and mem_fault both clear to 0.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds three 32-bit outputs, all reset to 0.
  - perf_stall_cycles: +1 per cycle in which any stall is 1.
  - perf_flush_events: +1 per cycle in which if_id_flush or id_ex_flush is 1.
  - perf_timeouts: +1 per forced release.
  - All three counters wrap modulo 2^32.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Load-use: EX_MemRead=1, EX_Rd=5, ID_Rs1=5, ID_UsesRs1=1 → pc_stall=1, if_id_stall=1, id_ex_flush=1 for exactly 1 cycle. The same case with EX_Rd=0 gives all outputs 0.
- Redirect: EX_Redirect pulses 1 cycle with REDIRECT_SHADOW=1 → if_id_flush=1 and id_ex_flush=1 in that cycle, then if_id_flush=1 and id_ex_flush=1 again in the next cycle. With REDIRECT_SHADOW=0, the flush lasts 1 cycle only.
- Dmem wait: MEM_MemRead=1, dmem_ready low for 3 cycles then high → freeze for 3 cycles, wait_count steps 1, 2, 3, then 0. mem_wb_flush=1 during the 3 frozen cycles. mem_fault stays 0.
- Timeout: TIMEOUT=4, dmem_ready held 0 → freeze with wait_count 1..4, then release. mem_fault=1 from the next cycle and stays 1 through later traffic until reset.
- Priority: freeze, EX_Redirect and load_use all true together → only the freeze outputs are asserted. After dmem_ready, the redirect flush appears.
- Async reset mid-WAIT (wait_count=2) → all outputs and wait_count drop to 0 immediately, without waiting for a clk edge. Under HAZARD_PERF_EN, the perf counters also read 0.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/bubble generator for the 5-stage pipeline registers: load-use, EX redirect,
// dmem/imem wait handling with a timeout watchdog. Optional perf counters under HAZARD_PERF_EN.
module pipeline_hazard_controller #(
  parameter int TIMEOUT         = 64,
  parameter int CNT_W           = 8,
  parameter bit REDIRECT_SHADOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_Rs1,
  input  logic [4:0]       ID_Rs2,
  input  logic             ID_UsesRs1,
  input  logic             ID_UsesRs2,
  input  logic [4:0]       EX_Rd,
  input  logic             EX_MemRead,
  input  logic             EX_Redirect,
  input  logic             MEM_MemRead,
  input  logic             MEM_MemWrite,
  input  logic             dmem_ready,
  input  logic             imem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             mem_wb_flush,
  output logic             mem_fault,
  output logic [CNT_W-1:0] wait_count,
  output logic             dbg_wait_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      perf_stall_cycles,
  output logic [31:0]      perf_flush_events,
  output logic [31:0]      perf_timeouts
`endif
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_count_q, wait_count_d;
  logic             fault_q, fault_d;
  logic             shadow_q, shadow_d;

  logic mem_access;
  logic load_use;
  logic redir;
  logic at_timeout;
  logic freeze;
  logic timeout_release;

  assign mem_access = MEM_MemRead | MEM_MemWrite;
  assign load_use   = EX_MemRead && (EX_Rd != 5'd0) &&
                      ((ID_UsesRs1 && (ID_Rs1 == EX_Rd)) ||
                       (ID_UsesRs2 && (ID_Rs2 == EX_Rd)));
  assign redir      = EX_Redirect | shadow_q;

  // The watchdog lets the stuck access retire on the cycle the count reaches TIMEOUT.
  assign at_timeout      = (state_q == S_WAIT) && (wait_count_q == TIMEOUT_C);
  assign freeze          = mem_access && !dmem_ready && !at_timeout;
  assign timeout_release = at_timeout && mem_access && !dmem_ready;

  always_comb begin
    state_d      = state_q;
    wait_count_d = '0;
    fault_d      = fault_q;
    case (state_q)
      S_RUN: begin
        if (freeze) begin
          state_d      = S_WAIT;
          wait_count_d = CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (!mem_access || dmem_ready) begin
          state_d = S_RUN;
        end else if (at_timeout) begin
          state_d = S_RUN;
          fault_d = 1'b1;
        end else begin
          wait_count_d = wait_count_q + 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // A redirect seen while frozen is not latched: EX is held and presents it again on release.
  assign shadow_d = REDIRECT_SHADOW ? (EX_Redirect && !freeze) : 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_RUN;
      wait_count_q <= '0;
      fault_q      <= 1'b0;
      shadow_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_count_q <= wait_count_d;
      fault_q      <= fault_d;
      shadow_q     <= shadow_d;
    end
  end

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_flush = 1'b0;
    if (!reset) begin
      if (freeze) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (redir) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end else if (!imem_ready) begin
        pc_stall    = 1'b1;
        if_id_flush = 1'b1;
      end
    end
  end

  assign mem_fault  = fault_q;
  assign wait_count = wait_count_q;
  assign dbg_wait_o = (state_q == S_WAIT);

`ifdef HAZARD_PERF_EN
  logic        stall_any;
  logic        flush_any;
  logic [31:0] perf_stall_q, perf_flush_q, perf_to_q;

  assign stall_any = pc_stall | if_id_stall | id_ex_stall | ex_mem_stall;
  assign flush_any = if_id_flush | id_ex_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_to_q    <= '0;
    end else begin
      if (stall_any)       perf_stall_q <= perf_stall_q + 32'd1;
      if (flush_any)       perf_flush_q <= perf_flush_q + 32'd1;
      if (timeout_release) perf_to_q    <= perf_to_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_events = perf_flush_q;
  assign perf_timeouts     = perf_to_q;
`else
  logic unused_release;
  assign unused_release = timeout_release;
`endif

  a_if_id_excl: assert property (@(posedge clk) disable iff (reset) !(if_id_stall && if_id_flush));
  a_id_ex_excl: assert property (@(posedge clk) disable iff (reset) !(id_ex_stall && id_ex_flush));

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: two instances (shadow flush on/off, TIMEOUT=4)
// compared each cycle against a per-cycle reference model of the hazard rules.
module tb_pipeline_hazard_controller;

  localparam int TO = 4;
  localparam int CW = 8;
  localparam int W  = 32;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] ID_Rs1, ID_Rs2, EX_Rd;
  logic       ID_UsesRs1, ID_UsesRs2, EX_MemRead, EX_Redirect;
  logic       MEM_MemRead, MEM_MemWrite, dmem_ready, imem_ready;

  logic          a_pc, a_ifs, a_iff, a_ids, a_idf, a_exs, a_mwf, a_fault, a_dbg;
  logic          b_pc, b_ifs, b_iff, b_ids, b_idf, b_exs, b_mwf, b_fault, b_dbg;
  logic [CW-1:0] a_wc, b_wc;
`ifdef HAZARD_PERF_EN
  logic [31:0] a_ps, a_pf, a_pt, b_ps, b_pf, b_pt;
`endif

  pipeline_hazard_controller #(.TIMEOUT(TO), .CNT_W(CW), .REDIRECT_SHADOW(1'b1)) dut_a (
    .clk(clk), .reset(reset),
    .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_UsesRs1(ID_UsesRs1), .ID_UsesRs2(ID_UsesRs2),
    .EX_Rd(EX_Rd), .EX_MemRead(EX_MemRead), .EX_Redirect(EX_Redirect),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .dmem_ready(dmem_ready), .imem_ready(imem_ready),
    .pc_stall(a_pc), .if_id_stall(a_ifs), .if_id_flush(a_iff), .id_ex_stall(a_ids),
    .id_ex_flush(a_idf), .ex_mem_stall(a_exs), .mem_wb_flush(a_mwf),
    .mem_fault(a_fault), .wait_count(a_wc), .dbg_wait_o(a_dbg)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles(a_ps), .perf_flush_events(a_pf), .perf_timeouts(a_pt)
`endif
  );

  pipeline_hazard_controller #(.TIMEOUT(TO), .CNT_W(CW), .REDIRECT_SHADOW(1'b0)) dut_b (
    .clk(clk), .reset(reset),
    .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_UsesRs1(ID_UsesRs1), .ID_UsesRs2(ID_UsesRs2),
    .EX_Rd(EX_Rd), .EX_MemRead(EX_MemRead), .EX_Redirect(EX_Redirect),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .dmem_ready(dmem_ready), .imem_ready(imem_ready),
    .pc_stall(b_pc), .if_id_stall(b_ifs), .if_id_flush(b_iff), .id_ex_stall(b_ids),
    .id_ex_flush(b_idf), .ex_mem_stall(b_exs), .mem_wb_flush(b_mwf),
    .mem_fault(b_fault), .wait_count(b_wc), .dbg_wait_o(b_dbg)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles(b_ps), .perf_flush_events(b_pf), .perf_timeouts(b_pt)
`endif
  );

  logic [W-1:0] obs;
  assign obs = {a_pc, a_ifs, a_iff, a_ids, a_idf, a_exs, a_mwf,
                b_pc, b_ifs, b_iff, b_ids, b_idf, b_exs, b_mwf,
                a_wc, b_wc, a_fault, b_fault};

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  int total = 0;
  int bad   = 0;

  int m_cnt;      // consecutive frozen cycles of the access in MEM
  bit m_fault;
  bit m_shadow;   // pending shadow flush for the shadow-enabled instance

  function automatic bit model_freeze();
    bit acc;
    acc = MEM_MemRead || MEM_MemWrite;
    return acc && !dmem_ready && (m_cnt != TO);
  endfunction

  // Output row per cycle, {pc, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush}
  function automatic logic [6:0] model_outs(input bit shadow);
    bit lu;
    lu = EX_MemRead && (EX_Rd != 5'd0) &&
         ((ID_UsesRs1 && ID_Rs1 == EX_Rd) || (ID_UsesRs2 && ID_Rs2 == EX_Rd));
    if (model_freeze())             return 7'b1101011;
    if (EX_Redirect || shadow)      return 7'b0010100;
    if (lu)                         return 7'b1100100;
    if (!imem_ready)                return 7'b1010000;
    return 7'b0000000;
  endfunction

  task automatic push_expected();
    exp_q.push_back({model_outs(m_shadow), model_outs(1'b0),
                     8'(m_cnt), 8'(m_cnt), m_fault, m_fault});
  endtask

  task automatic model_step();
    bit fz;
    fz = model_freeze();
    if ((MEM_MemRead || MEM_MemWrite) && !dmem_ready && m_cnt == TO) m_fault = 1'b1;
    m_shadow = EX_Redirect && !fz;
    m_cnt    = fz ? m_cnt + 1 : 0;
  endtask

  task automatic model_reset();
    m_cnt = 0; m_fault = 1'b0; m_shadow = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  function automatic logic [22:0] mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic u1, input logic u2, input logic [4:0] rd,
                                     input logic exmr, input logic exr, input logic mr,
                                     input logic mw, input logic dr, input logic ir);
    return {rs1, rs2, u1, u2, rd, exmr, exr, mr, mw, dr, ir};
  endfunction

  task automatic apply(input logic [22:0] v);
    {ID_Rs1, ID_Rs2, ID_UsesRs1, ID_UsesRs2, EX_Rd, EX_MemRead, EX_Redirect,
     MEM_MemRead, MEM_MemWrite, dmem_ready, imem_ready} = v;
  endtask

  logic [22:0] idle_v;
  initial idle_v = 23'b11;

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    apply(mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    total++;
    if (obs !== '0) begin
      bad++; $display("FAIL reset_hold got=%h want=%h", obs, {W{1'b0}});
    end
    apply(idle_v);
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      push_expected(); exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL reset_idle cyc=%0d got=%h want=%h", i, obs, exp_v); end
      model_step();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    logic [22:0] v[$];
    v.push_back(mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    v.push_back(idle_v);
    v.push_back(mk(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    v.push_back(mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    v.push_back(mk(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    v.push_back(mk(5'd7, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    v.push_back(mk(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    foreach (v[i]) begin
      apply(v[i]);
      @(negedge clk);
      push_expected(); exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL load_use cyc=%0d got=%h want=%h", i, obs, exp_v); end
      model_step();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect();
    logic [22:0] v[$];
    v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    v.push_back(idle_v);
    v.push_back(idle_v);
    v.push_back(mk(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    v.push_back(mk(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    v.push_back(idle_v);
    foreach (v[i]) begin
      apply(v[i]);
      @(negedge clk);
      push_expected(); exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL redirect cyc=%0d got=%h want=%h", i, obs, exp_v); end
      model_step();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_dmem_wait();
    logic [22:0] v[$];
    for (int k = 0; k < 3; k++)
      v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1));
    v.push_back(idle_v);
    v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    v.push_back(idle_v);
    foreach (v[i]) begin
      apply(v[i]);
      @(negedge clk);
      push_expected(); exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL dmem_wait cyc=%0d got=%h want=%h", i, obs, exp_v); end
      model_step();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority();
    logic [22:0] v[$];
    for (int k = 0; k < 2; k++)
      v.push_back(mk(5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    v.push_back(mk(5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    v.push_back(idle_v);
    foreach (v[i]) begin
      apply(v[i]);
      @(negedge clk);
      push_expected(); exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL priority cyc=%0d got=%h want=%h", i, obs, exp_v); end
      model_step();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    logic [22:0] v[$];
    for (int k = 0; k < TO + 3; k++)
      v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
    v.push_back(idle_v);
    v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    v.push_back(idle_v);
    foreach (v[i]) begin
      apply(v[i]);
      @(negedge clk);
      push_expected(); exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL timeout cyc=%0d got=%h want=%h", i, obs, exp_v); end
      model_step();
      @(posedge clk); #1;
    end
    total++;
    if (a_fault !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b want=1", a_fault); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply(mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 99) < 40),
               1'($urandom_range(0, 99) < 20), 1'($urandom_range(0, 99) < 40),
               1'($urandom_range(0, 99) < 25), 1'($urandom_range(0, 99) < 45),
               1'($urandom_range(0, 99) < 80)));
      @(negedge clk);
      push_expected(); exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs, exp_v); end
      model_step();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    apply(idle_v);
    reset = 1'b1; #2; reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      apply(mk(5'd2, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      push_expected(); exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL async_pre cyc=%0d got=%h want=%h", i, obs, exp_v); end
      model_step();
      @(posedge clk); #1;
    end
    total++;
    if (a_wc !== 8'd2) begin bad++; $display("FAIL async_wc2 got=%0d want=2", a_wc); end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL async_reset got=%h want=%h", obs, {W{1'b0}}); end
`ifdef HAZARD_PERF_EN
    total++;
    if ({a_ps, a_pf, a_pt, b_ps, b_pf, b_pt} !== '0) begin
      bad++; $display("FAIL async_perf got=%h/%h/%h want=0", a_ps, a_pf, a_pt);
    end
`endif
    apply(idle_v);
    #2;
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    @(negedge clk);
    push_expected(); exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL async_post got=%h want=%h", obs, exp_v); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_redirect();
    test_dmem_wait();
    test_priority();
    test_timeout();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
